// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default bit timing and the receiver state encoding.
// The transmit-side serializer reuses these so both directions agree on framing.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 868;  // 100 MHz / 115200 baud

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
// The reset value is a parameter so idle-high lines such as UART RX come out of reset idle.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver: samples mid-bit, assembles bytes LSB first and presents them on a
// valid/ready holding register, with single-cycle frame_err and overrun status pulses.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_i),
    .q     (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 load, ovr_set, ferr_set;

  // NOTE: every signal written here gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    load     = 1'b0;
    ovr_set  = 1'b0;
    ferr_set = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;  // line back high mid-start-bit: a glitch
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            ferr_set = 1'b1;
            state_d  = WAIT_HIGH;
          end else begin
            state_d = IDLE;
            // The slot is free if empty or being drained on this very edge.
            if (!m_valid || m_ready) load    = 1'b1;
            else                     ovr_set = 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: the shift register and holding register are cleared on reset even though
  // their contents are qualified by state/m_valid, so m_data reads 0x00 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      frame_err <= ferr_set;
      overrun   <= ovr_set;
      if (load) begin
        m_data  <= shift_q;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer: serial frames are driven bit by bit and a
// scoreboard predicts each byte, its arrival cycle and the status pulses from the framing rules.
module tb_uart_rx_framer;

  localparam int CPB  = 16;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 1 + CPB / 2 + 9 * CPB;  // start edge to m_valid: 155

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_i = 1'b1;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_valid, frame_err, overrun, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Observed traffic, filled by the monitor.
  logic [7:0] got_d[$];
  int         got_t[$];
  int         ferr_t[$];
  int         ovr_t[$];
  int         both_n = 0;
  bit         busy_seen = 1'b0;

  // Scoreboard expectations, filled by the model.
  logic [7:0] exp_d[$];
  int         exp_t[$];
  int         exp_ferr[$];

  logic       pv_valid = 1'b0, pv_ready = 1'b0;
  logic [7:0] pv_data = '0;

  uart_rx_framer #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_i      (rx_i),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_t.push_back(cyc);
      end
      if (frame_err) ferr_t.push_back(cyc);
      if (overrun) ovr_t.push_back(cyc);
      if (frame_err && overrun) both_n++;
      if (busy) busy_seen = 1'b1;
      if (pv_valid && !pv_ready) begin
        check("hold_valid", m_valid, 1'b1);
        check("hold_data", m_data, pv_data);
      end
      pv_valid = m_valid;
      pv_ready = m_ready;
      pv_data  = m_data;
    end else begin
      pv_valid = 1'b0;
      pv_ready = 1'b0;
    end
  end

  // Called just after a rising edge; returns just after the n-th following rising edge.
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, output int t0);
    t0   = cyc;
    rx_i = 1'b0;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      hold(CPB);
    end
    rx_i = stop;
    hold(CPB);
  endtask

  // Reference model: a frame with a high stop bit delivers its byte LAT cycles after
  // its start edge (receiver always ready); a low stop bit raises frame_err at that point.
  task automatic model_frame(input logic [7:0] d, input logic stop, input int t0);
    if (stop) begin
      exp_d.push_back(d);
      exp_t.push_back(t0 + LAT);
    end else begin
      exp_ferr.push_back(t0 + LAT);
    end
  endtask

  task automatic clear();
    got_d.delete(); got_t.delete(); ferr_t.delete(); ovr_t.delete();
    exp_d.delete(); exp_t.delete(); exp_ferr.delete();
    busy_seen = 1'b0;
  endtask

  task automatic score(input string tag);
    check($sformatf("%s_count", tag), got_d.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
      check($sformatf("%s_time%0d", tag, i), got_t[i], exp_t[i]);
    end
    check($sformatf("%s_ferr_count", tag), ferr_t.size(), exp_ferr.size());
    for (int i = 0; i < exp_ferr.size() && i < ferr_t.size(); i++)
      check($sformatf("%s_ferr_time%0d", tag, i), ferr_t[i], exp_ferr[i]);
    check($sformatf("%s_ovr_count", tag), ovr_t.size(), 0);
  endtask

  task automatic run_good(input string tag, input logic [7:0] d);
    int t0;
    clear();
    send_frame(d, 1'b1, t0);
    model_frame(d, 1'b1, t0);
    rx_i = 1'b1;
    hold(10);
    score(tag);
  endtask

  initial begin
    int t0, t1, t2;
    logic [7:0] d;
    logic stop;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_data", m_data, 8'h00);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    hold(5);

    // Single frame with nominal latency.
    run_good("single_a5", 8'hA5);

    // Back-to-back frames, no idle gap.
    clear();
    send_frame(8'h00, 1'b1, t0); model_frame(8'h00, 1'b1, t0);
    send_frame(8'hFF, 1'b1, t0); model_frame(8'hFF, 1'b1, t0);
    send_frame(8'h3C, 1'b1, t0); model_frame(8'h3C, 1'b1, t0);
    rx_i = 1'b1;
    hold(10);
    score("b2b");
    if (got_t.size() == 3) begin
      check("b2b_gap1", got_t[1] - got_t[0], 160);
      check("b2b_gap2", got_t[2] - got_t[1], 160);
    end

    // Overrun: holding register stays full while a second frame completes.
    clear();
    m_ready = 1'b0;
    send_frame(8'h11, 1'b1, t1);
    send_frame(8'h22, 1'b1, t2);
    rx_i = 1'b1;
    hold(5);
    check("ovr_valid", m_valid, 1'b1);
    check("ovr_data", m_data, 8'h11);
    check("ovr_count", ovr_t.size(), 1);
    if (ovr_t.size() == 1) check("ovr_time", ovr_t[0], t2 + LAT);
    check("ovr_no_xfer", got_d.size(), 0);
    m_ready = 1'b1;
    hold(3);
    check("ovr_xfer_count", got_d.size(), 1);
    if (got_d.size() == 1) check("ovr_xfer_data", got_d[0], 8'h11);
    check("ovr_valid_clear", m_valid, 1'b0);

    // Framing error followed by a long break.
    clear();
    send_frame(8'h55, 1'b0, t0);
    model_frame(8'h55, 1'b0, t0);
    hold(40 * CPB);
    check("ferr_busy_in_break", busy, 1'b1);
    rx_i = 1'b1;
    hold(6);
    check("ferr_busy_after", busy, 1'b0);
    score("ferr");
    run_good("after_ferr_81", 8'h81);

    // Short low glitch on an idle line.
    clear();
    rx_i = 1'b0;
    hold(4);
    rx_i = 1'b1;
    hold(30);
    check("glitch_busy_seen", busy_seen, 1'b1);
    check("glitch_busy_end", busy, 1'b0);
    score("glitch");
    run_good("after_glitch_7e", 8'h7E);

    // Reset asserted during data bit 4.
    clear();
    fork
      send_frame(8'hC3, 1'b1, t0);
      begin
        hold(5 * CPB + CPB / 2);
        rst_n = 1'b0;
        #1;
        check("midrst_m_data", m_data, 8'h00);
        check("midrst_m_valid", m_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_frame_err", frame_err, 1'b0);
        check("midrst_overrun", overrun, 1'b0);
      end
    join
    rx_i = 1'b1;
    hold(3);
    rst_n = 1'b1;
    hold(20);
    score("midrst_none");
    run_good("after_rst_c3", 8'hC3);

    // Randomized frames with random gaps and occasional bad stop bits.
    clear();
    for (int n = 0; n < 12; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(d, stop, t0);
      model_frame(d, stop, t0);
      rx_i = 1'b1;
      if (stop) begin
        t1 = $urandom_range(0, 20);
        if (t1 > 0) hold(t1);
      end else begin
        hold($urandom_range(4, 20));
      end
    end
    hold(10);
    score("rand");

    check("never_both_flags", both_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- Serial-to-parallel UART receiver; sits directly upstream of the byte FIFO inside tt_uart_fifo.
- Takes the raw asynchronous RX line (uio_in bit at top level) and emits one 8N1 byte per frame on a valid/ready interface into the FIFO write port.
- Flags framing errors and overruns as single-cycle pulses for status/debug.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 8..65535.
- SYNC_STAGES, 2, flops in the RX input synchronizer; legal range 2..3.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_i  in  1  raw serial line; idle high; LSB first; 8 data bits, no parity, 1 stop bit.
- m_data  out  8  received byte; stable while m_valid=1.
- m_valid  out  1  byte available for the FIFO.
- m_ready  in  1  FIFO can accept; transfer happens on a cycle with m_valid & m_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: good frame completed while the holding register was still full.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release):
  - Synchronizer flops = 1, state = IDLE, counters = 0.
  - m_data = 0x00; m_valid, frame_err, overrun, busy = 0.
- HALF = CLKS_PER_BIT/2 (floor). The bit counter is wide enough for CLKS_PER_BIT-1; the bit index is 3 bits.
- FSM states and transitions:
  - IDLE: when synced rx = 0, go to START and clear the counter.
  - START: count. When count reaches HALF-1, sample the line.
    - Sample = 0: go to DATA, clear counter, bit index = 0.
    - Sample = 1: glitch. Return to IDLE with no output and no flag.
  - DATA: each time count reaches CLKS_PER_BIT-1, sample into shift[bit index] (LSB first) and clear the counter.
    - After bit 7, go to STOP.
  - STOP: when count reaches CLKS_PER_BIT-1, sample the stop bit.
    - Stop = 1 and holding register free (m_valid=0, or m_valid & m_ready in this same cycle): load m_data, set m_valid on the next edge, go to IDLE.
    - Stop = 1 and holding register full with m_ready=0: pulse overrun, discard the new byte, keep the old m_data/m_valid, go to IDLE.
    - Stop = 0: pulse frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until synced rx = 1, then go to IDLE. This prevents a break condition from being decoded as repeated 0x00 frames.
- Latency: from the rx_i falling edge of the start bit to m_valid rising is exactly SYNC_STAGES + 1 + HALF + 9*CLKS_PER_BIT cycles. With CLKS_PER_BIT=16 and SYNC_STAGES=2 this is 155.
- Output handshake:
  - m_valid stays high until a cycle with m_ready=1; it clears on the following edge unless a new byte loads in that same cycle, in which case m_valid stays 1 and m_data updates.
  - m_data never changes while m_valid=1 and m_ready=0.
- Back-to-back frames: a new start bit is accepted on the first IDLE cycle after STOP. There are no dead cycles beyond the FSM transition.
- The holding register is independent of the FSM, so reception continues while m_valid is pending.
- frame_err and overrun are never asserted together.
- Reset mid-frame: immediate return to the reset values. A partial frame is never emitted, and a pending m_valid byte is lost.

Decomposition:
- Package uart_pkg:
  - State enum: IDLE, START, DATA, STOP, WAIT_HIGH.
  - Constants: DATA_BITS=8 and default CLKS_PER_BIT.
  - Shared with the future uart_tx_serializer.
- One sub-module, sync_ff: a SYNC_STAGES-deep synchronizer with a parameterizable reset value (1 here), reused on other top-level inputs.

Test Plan (CLKS_PER_BIT=16, SYNC_STAGES=2, m_ready=1 unless stated):
- Single frame 0xA5 -> m_valid high for 1 cycle exactly 155 cycles after the start edge, m_data=0xA5, no flags.
- Bytes 0x00, 0xFF, 0x3C back-to-back with no idle gap -> three handshakes in order, 160 cycles apart, no flags.
- m_ready=0, send 0x11 then 0x22 -> m_data holds 0x11, one overrun pulse at the second STOP sample. Raise m_ready -> one transfer of 0x11, then m_valid=0.
- Frame 0x55 with stop bit driven 0 and the line held low 40 more bit-times -> one frame_err pulse, no m_valid, busy stays high until rx returns high. A following 0x81 is received correctly.
- rx_i low pulse of 4 cycles -> busy rises then falls, no m_valid, no flags. A subsequent 0x7E is received correctly.
- rst_n asserted during bit 4 of a frame -> all outputs 0 immediately, busy=0. After release, a fresh 0xC3 is received with the nominal 155-cycle latency.
